// File: rtl/riscv_pipe_pkg.sv
// Shared types and default parameters for the IF/MEM memory-port arbiter.
// Holds the FSM state and owner encodings plus the default latency/window.
// No logic; imported by mem_port_arbiter and its latency timer.
package riscv_pipe_pkg;

  localparam int DEF_MEM_LAT  = 2;
  localparam int DEF_MAX_DWIN = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Latency counter: loaded with MEM_LAT-1 on a grant, counts down to zero.
// zero_o is high when the count is exhausted (response cycle while waiting).
// No backpressure; a load always wins over the decrement.
module mem_lat_timer
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic zero_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on grant, otherwise run down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(MEM_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and MEM data port onto one single-port memory.
// Fixed MEM_LAT cycles grant->response; regrant possible in the response cycle.
// Stalls each port while its request is pending; ARB_PERF_CNT_EN adds perf counters.
module mem_port_arbiter
  import riscv_pipe_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int MAX_DWIN = DEF_MAX_DWIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]         conflict_cnt,
  output logic [31:0]         istall_cnt,
`endif
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int DW = (MAX_DWIN > 0) ? $clog2(MAX_DWIN + 1) : 1;

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic [DW-1:0] dwin_q, dwin_d;
  logic          kill_q, kill_d;
  logic          we_q, we_d;
  logic          lat_zero;
  logic          resp, can_grant, i_elig, d_elig, grant_i, grant_d;

  mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (grant_i | grant_d),
    .zero_o (lat_zero)
  );

  // Response cycle, eligibility and priority; a port never regrants itself in its own response cycle.
  always_comb begin
    resp      = (state_q == WAIT) && lat_zero;
    can_grant = !rst && ((state_q == IDLE) || resp);
    i_elig    = !rst && i_req && !flush && !(resp && owner_q == OWN_I);
    d_elig    = !rst && d_req && !(resp && owner_q == OWN_D);
    grant_i   = can_grant && i_elig && (!d_elig || (dwin_q == DW'(MAX_DWIN)));
    grant_d   = can_grant && d_elig && !grant_i;
  end

  // FSM, owner, D-window and sticky flush-kill next state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dwin_d  = dwin_q;
    kill_d  = kill_q;
    we_d    = we_q;
    if (grant_i || grant_d) begin
      state_d = WAIT;
      owner_d = grant_i ? OWN_I : OWN_D;
      we_d    = grant_d && d_we;
    end else if (resp) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
      we_d    = 1'b0;
    end
    if (grant_i || (grant_d && !i_req)) begin
      dwin_d = '0;
    end else if (grant_d && dwin_q != DW'(MAX_DWIN)) begin
      dwin_d = dwin_q + DW'(1);
    end
    // Memory cannot cancel, so a flushed fetch is waited out and its data dropped.
    if (state_q == WAIT && !resp && owner_q == OWN_I && flush) begin
      kill_d = 1'b1;
    end else if (resp || state_q == IDLE) begin
      kill_d = 1'b0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      dwin_q  <= '0;
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dwin_q  <= dwin_d;
      kill_q  <= kill_d;
      we_q    <= we_d;
    end
  end

  // Responses, stalls and the memory bus, all forced to zero when not qualified.
  always_comb begin
    i_valid   = resp && owner_q == OWN_I && !kill_q && !flush;
    d_valid   = resp && owner_q == OWN_D;
    i_rdata   = i_valid ? mem_rdata : '0;
    d_rdata   = (d_valid && !we_q) ? mem_rdata : '0;
    i_stall   = !rst && i_req && !i_valid;
    d_stall   = !rst && d_req && !d_valid;
    mem_req   = grant_i || grant_d;
    mem_we    = grant_d && d_we;
    mem_addr  = grant_i ? i_addr : (grant_d ? d_addr : '0);
    mem_wdata = grant_d ? d_wdata : '0;
    mem_be    = grant_d ? d_be : '0;
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, istall_cnt_q;

  // Saturating counters for both-eligible cycles and fetch-stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      istall_cnt_q   <= '0;
    end else begin
      if (i_elig && d_elig && conflict_cnt_q != '1) conflict_cnt_q <= conflict_cnt_q + 32'd1;
      if (i_stall && istall_cnt_q != '1)            istall_cnt_q   <= istall_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign istall_cnt   = istall_cnt_q;
`endif

endmodule
